// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
//   Shared encodings for the fetch / load-store memory arbiter:
//   controller state encoding, grant identifiers and memory direction values.
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    // Grant identifiers (one bit: the "other" requester is the inverse)
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    // Memory transaction direction
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Fetches always move a full word
    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

endpackage

// File: rtl/memory_arbiter_rr_picker_2.sv
// -----------------------------------------------------------------------------
// rr_picker_2
//   Combinational two-way round-robin chooser.
//   Ports:
//     fetch_request  in  fetch requester is asking
//     data_request   in  load/store requester is asking
//     last_grant     in  requester granted most recently (GRANT_FETCH/GRANT_DATA)
//     valid          out at least one request present
//     grant          out chosen requester; on contention, the one not granted last
// -----------------------------------------------------------------------------
module rr_picker_2
    import memory_arbiter_pkg::*;
(
    input  logic fetch_request,
    input  logic data_request,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        valid = fetch_request | data_request;
        grant = GRANT_DATA;
        if (fetch_request && data_request) begin
            grant = ~last_grant;
        end else if (fetch_request) begin
            grant = GRANT_FETCH;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//   Shares one memory port between instruction fetch and load/store.
//   One transaction at a time, round-robin on contention, timeout -> bus error.
//   Ports:
//     CLK, reset                         clock (rising edge), async active-high reset
//     fetch_request/address              fetch read request
//     fetch_data/fetch_done              fetch result and one-cycle completion
//     data_request/write/frame_mask/
//       address/write_data               load/store request and attributes
//     data_read_data/data_done           load result and one-cycle completion
//     mem_enable/write/frame_mask/
//       address/write_data               registered memory request
//     mem_read_data/mem_done             memory response
//     bus_error                          accompanies a done that ended by timeout
//   Parameter TIMEOUT_CYCLES: BUSY cycles without mem_done before a forced
//   error completion; 0 disables the timeout.
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_done,
    input  logic        data_request,
    input  logic        data_write,
    input  logic [3:0]  data_frame_mask,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic [31:0] data_read_data,
    output logic        data_done,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [3:0]  mem_frame_mask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_done,
    output logic        bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // The counter holds the number of BUSY cycles already elapsed, so the
    // timeout fires on the edge that would make it reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic             last_grant;
    logic             grant;
    logic [CNT_W-1:0] count;
    logic             pick_valid;
    logic             pick_grant;
    logic             timeout_hit;

    rr_picker_2 u_picker (
        .fetch_request (fetch_request),
        .data_request  (data_request),
        .last_grant    (last_grant),
        .valid         (pick_valid),
        .grant         (pick_grant)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == TIMEOUT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            last_grant     <= GRANT_DATA;
            grant          <= GRANT_FETCH;
            count          <= '0;
            fetch_data     <= '0;
            fetch_done     <= 1'b0;
            data_read_data <= '0;
            data_done      <= 1'b0;
            mem_enable     <= 1'b0;
            mem_write      <= MEM_READ;
            mem_frame_mask <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            bus_error      <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses
            fetch_done <= 1'b0;
            data_done  <= 1'b0;
            bus_error  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick_grant;
                        last_grant <= pick_grant;
                        count      <= '0;
                        mem_enable <= 1'b1;
                        state      <= ST_BUSY;
                        if (pick_grant == GRANT_FETCH) begin
                            mem_write      <= MEM_READ;
                            mem_frame_mask <= FULL_WORD_MASK;
                            mem_address    <= fetch_address;
                            mem_write_data <= '0;
                        end else begin
                            mem_write      <= data_write;
                            mem_frame_mask <= data_frame_mask;
                            mem_address    <= data_address;
                            mem_write_data <= data_write_data;
                        end
                    end
                end

                ST_BUSY: begin
                    // mem_done takes priority over a timeout on the same edge
                    if (mem_done) begin
                        mem_enable <= 1'b0;
                        state      <= ST_RESPOND;
                        if (grant == GRANT_FETCH) begin
                            fetch_done <= 1'b1;
                            if (mem_write == MEM_READ) fetch_data <= mem_read_data;
                        end else begin
                            data_done <= 1'b1;
                            if (mem_write == MEM_READ) data_read_data <= mem_read_data;
                        end
                    end else if (timeout_hit) begin
                        mem_enable <= 1'b0;
                        bus_error  <= 1'b1;
                        state      <= ST_RESPOND;
                        if (grant == GRANT_FETCH) begin
                            fetch_done <= 1'b1;
                            fetch_data <= '0;
                        end else begin
                            data_done      <= 1'b1;
                            data_read_data <= '0;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        count <= count + CNT_W'(1);
                    end
                end

                // Done pulse is visible during this single cycle; requests
                // are deliberately not sampled here.
                ST_RESPOND: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//   Self-checking bench for memory_arbiter (TIMEOUT_CYCLES = 4). The bench
//   plays both requesters and the memory; a transaction-level model predicts
//   the winner, the memory request, completion flags and held result words.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int T = 4;

    logic        CLK = 1'b0;
    logic        reset;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        fetch_done;
    logic        data_request;
    logic        data_write;
    logic [3:0]  data_frame_mask;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;
    logic        data_done;
    logic        mem_enable;
    logic        mem_write;
    logic [3:0]  mem_frame_mask;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_done;
    logic        bus_error;

    memory_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .fetch_request   (fetch_request),
        .fetch_address   (fetch_address),
        .fetch_data      (fetch_data),
        .fetch_done      (fetch_done),
        .data_request    (data_request),
        .data_write      (data_write),
        .data_frame_mask (data_frame_mask),
        .data_address    (data_address),
        .data_write_data (data_write_data),
        .data_read_data  (data_read_data),
        .data_done       (data_done),
        .mem_enable      (mem_enable),
        .mem_write       (mem_write),
        .mem_frame_mask  (mem_frame_mask),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_done        (mem_done),
        .bus_error       (bus_error)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    logic        model_last_data;   // 1 when the data requester was granted most recently
    logic [31:0] exp_fdata;
    logic [31:0] exp_ddata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},   32'(mem_enable), 32'd0);
        check({tag, "_fd"},   32'(fetch_done), 32'd0);
        check({tag, "_dd"},   32'(data_done),  32'd0);
        check({tag, "_berr"}, 32'(bus_error),  32'd0);
    endtask

    task automatic model_reset();
        model_last_data = 1'b1;
        exp_fdata       = '0;
        exp_ddata       = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_quiet(tag);
        check({tag, "_fdata"}, fetch_data,           32'd0);
        check({tag, "_ddata"}, data_read_data,       32'd0);
        check({tag, "_addr"},  mem_address,          32'd0);
        check({tag, "_mask"},  32'(mem_frame_mask),  32'd0);
        check({tag, "_wr"},    32'(mem_write),       32'd0);
        check({tag, "_wdata"}, mem_write_data,       32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("reset");
        step();
        reset = 1'b0;
    endtask

    // One complete transaction from IDLE. lat = BUSY cycles before mem_done
    // is presented; lat >= T means the memory stays silent past the timeout.
    // Called one time unit after a rising edge with the arbiter idle.
    task automatic txn(input int lat, input logic [31:0] rdata, output logic got_fetch);
        logic        win_data;
        logic        timed_out;
        logic [31:0] ea, ew;
        logic [3:0]  em;
        logic        ewr;
        int          waits;

        if (fetch_request && data_request) win_data = !model_last_data;
        else                               win_data = data_request;
        model_last_data = win_data;

        if (win_data) begin
            ea = data_address; em = data_frame_mask; ewr = data_write; ew = data_write_data;
        end else begin
            ea = fetch_address; em = 4'hF; ewr = 1'b0; ew = 32'd0;
        end
        timed_out = (lat >= T);
        waits     = timed_out ? T - 1 : lat;

        step();
        check("issue_en",    32'(mem_enable),     32'd1);
        check("issue_addr",  mem_address,         ea);
        check("issue_mask",  32'(mem_frame_mask), 32'(em));
        check("issue_wr",    32'(mem_write),      32'(ewr));
        check("issue_wdata", mem_write_data,      ew);

        for (int i = 0; i < waits; i++) begin
            mem_read_data = $urandom;
            step();
            check("busy_en",   32'(mem_enable),              32'd1);
            check("busy_addr", mem_address,                  ea);
            check("busy_done", 32'(fetch_done | data_done),  32'd0);
        end

        if (!timed_out) begin
            mem_done      = 1'b1;
            mem_read_data = rdata;
        end else begin
            mem_read_data = $urandom;
        end
        step();
        mem_done      = 1'b0;
        mem_read_data = $urandom;

        if (timed_out) begin
            if (win_data) exp_ddata = 32'd0; else exp_fdata = 32'd0;
        end else if (!ewr) begin
            if (win_data) exp_ddata = rdata; else exp_fdata = rdata;
        end
        got_fetch = fetch_done;
        check("resp_en",    32'(mem_enable), 32'd0);
        check("resp_fdone", 32'(fetch_done), 32'(!win_data));
        check("resp_ddone", 32'(data_done),  32'(win_data));
        check("resp_berr",  32'(bus_error),  32'(timed_out));
        check("resp_fdata", fetch_data,      exp_fdata);
        check("resp_ddata", data_read_data,  exp_ddata);

        // Winner drops its request once it has seen done
        if (win_data) data_request = 1'b0; else fetch_request = 1'b0;
        step();
        check_quiet("after_resp");
        check("hold_fdata", fetch_data,     exp_fdata);
        check("hold_ddata", data_read_data, exp_ddata);
    endtask

    task automatic raise_data(input logic wr);
        data_request    = 1'b1;
        data_write      = wr;
        data_frame_mask = 4'($urandom_range(1, 15));
        data_address    = $urandom;
        data_write_data = $urandom;
    endtask

    logic got_fetch;

    initial begin
        fetch_request   = 1'b0;
        fetch_address   = '0;
        data_request    = 1'b0;
        data_write      = 1'b0;
        data_frame_mask = '0;
        data_address    = '0;
        data_write_data = '0;
        mem_done        = 1'b0;
        mem_read_data   = '0;

        do_reset();

        // Fetch alone, memory answers after two BUSY cycles
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0100;
        txn(2, 32'h0000_0013, got_fetch);
        check("fetch_only_data", fetch_data, 32'h0000_0013);

        // Sustained contention from reset: F,D,F,D,F,D
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (!fetch_request) begin
                fetch_request = 1'b1;
                fetch_address = $urandom;
            end
            if (!data_request) raise_data(1'b0);
            txn(1, $urandom, got_fetch);
            check("rr_order", 32'(got_fetch), 32'((i % 2) == 0));
        end
        fetch_request = 1'b0;
        data_request  = 1'b0;

        // Byte-masked store leaves the load result untouched
        data_request    = 1'b1;
        data_write      = 1'b1;
        data_frame_mask = 4'b0011;
        data_address    = 32'h0000_0200;
        data_write_data = 32'hDEAD_BEEF;
        txn(1, $urandom, got_fetch);

        // Memory never answers: bus error after T BUSY cycles
        data_request    = 1'b1;
        data_write      = 1'b0;
        data_frame_mask = 4'hF;
        data_address    = 32'h0000_0300;
        txn(T, $urandom, got_fetch);
        check("timeout_ddata", data_read_data, 32'd0);
        step();
        check_quiet("timeout_idle");

        // mem_done on the edge the timeout would expire: normal completion
        data_request = 1'b1;
        data_address = 32'h0000_0304;
        txn(T - 1, 32'hCAFE_F00D, got_fetch);

        // Stray mem_done while idle is ignored
        mem_done      = 1'b1;
        mem_read_data = 32'h1234_5678;
        step();
        mem_done = 1'b0;
        check_quiet("stray_done");
        check("stray_fdata", fetch_data,     exp_fdata);
        check("stray_ddata", data_read_data, exp_ddata);
        step();
        check_quiet("stray_done2");

        // Reset in the middle of a BUSY transaction
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0400;
        step();
        check("midrst_busy", 32'(mem_enable), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        fetch_request = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("postrst");
        end
        fetch_request = 1'b1;
        fetch_address = 32'h0000_0404;
        txn(0, 32'h0BAD_F00D, got_fetch);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            if (!fetch_request && ($urandom_range(0, 1) == 1)) begin
                fetch_request = 1'b1;
                fetch_address = $urandom;
            end
            if (!data_request && (!fetch_request || ($urandom_range(0, 1) == 1)))
                raise_data(1'($urandom_range(0, 1)));
            txn($urandom_range(0, T + 1), $urandom, got_fetch);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
